rnn_accel: RTL and testbench
============================

Name: rnn_accel

Overview:
- Memory-mapped accelerator for a single Elman-style RNN cell: h_new = x·W + h·U + b.
- Fixed sizes: input length 2, hidden length 4, W is 2x4, U is 4x4, bias b is length 4.
- All values are 16-bit two's-complement integers, with no activation function and no fixed-point scaling.
- Sits behind a simple host bus (read/write/addr/data). The host loads weights, writes the input vector, pulses start, then reads back the hidden state.

Parameters:
- IN_LEN, 2, input vector length.
- HID_LEN, 4, hidden/output length.
- DW, 16, element width in bits (signed).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous reset, active-high despite its name; sampled on the clk rising edge.
- read  input  1  host read strobe.
- write  input  1  host write strobe, one transaction per cycle while high.
- addr  input  32  register select; only addr[3:0] is decoded.
- data_in  input  32  write data.
- data_out  output  32  read data, combinational from addr and current state.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - x, W, U, b and hidden all become 0; state becomes LOAD.
  - data_out is 0 while reset is asserted.
- Write map, evaluated only when write=1 and state=LOAD. The write takes effect at that edge and is visible the following cycle.
  - addr 0: START. State goes to START at the next edge.
  - addr 1: x[data_in[31:16]] <= data_in[15:0]. Indices ≥ 2 are ignored.
  - addr 2: W[data_in[31:24]][data_in[23:16]] <= data_in[15:0]. Row must be <2 and column <4, otherwise ignored.
  - addr 3: U[data_in[31:24]][data_in[23:16]] <= data_in[15:0]. Row and column must be <4, otherwise ignored.
  - addr 4: b[data_in[31:16]] <= data_in[15:0]. Indices ≥ 4 are ignored.
  - addr 5: hidden <= 0, clearing the recurrence without touching weights.
  - Any other addr: no effect.
  - Writes of any kind while state≠LOAD are ignored, including a repeated START.
- State machine: LOAD (idle) -> START -> MUL -> UPDATE -> LOAD.
  - START, 1 cycle: clears both partial-sum vectors wx[0..3] and uh[0..3]. Sub-multiplier ready flags go low.
  - MUL, 4 cycles, j=0..3, one output column per cycle:
    - wx[j] <= Σi x[i]*W[i][j]
    - uh[j] <= Σk hidden[k]*U[k][j], using the hidden value latched before this step.
  - End of MUL: both ready flags pulse high for 1 cycle, with wx and uh complete.
  - UPDATE, 1 cycle: hidden[j] <= wx[j] + uh[j] + b[j] for all j. State returns to LOAD at the next edge.
  - Total: hidden is valid in LOAD 6 cycles after the START write edge.
- Arithmetic: 16x16 signed products; all sums wrap modulo 2^16, keeping the low 16 bits. No saturation.
- The hidden state persists across START operations; this is the recurrence.
- Read map (combinational, independent of the read strobe):
  - addr 0: {31'b0, state==LOAD}, i.e. the done/idle flag.
  - addr 8..11: hidden[addr-8], sign-extended to 32 bits.
  - All other addresses return 0.
- Reset asserted mid-computation aborts immediately and reinitialises as above.
- read and write asserted together: the write applies, and data_out reflects pre-edge state.

Test Plan:
- Reset, then write x=(2,-3) via addr 1 with index 0 then index 1 -> x[0]=2 on the next cycle, x[1]=-3 on the cycle after.
- Load W rows (2,-10,-10,3),(6,9,12,1) via addr 2 and U rows (-2,-3,-5,-3),(-1,10,-2,-6),(4,11,3,-12),(-11,-4,3,-1) via addr 3, with per-element readback of internals -> each element matches on the cycle after its write.
- Load b=(-2,-2,-1,-1), then START -> state==START on the next cycle; wx=(-14,-47,-56,3); uh=(0,0,0,0); hidden=(-16,-49,-57,2) when back in LOAD; addr 8..11 read back those values sign-extended.
- Write x=(-8,3), then START -> wx=(2,107,116,-21); uh=(-169,-1077,13,1024); hidden=(-169,-972,128,1002).
- Writes to addr 1-4 and a second START issued during MUL -> ignored; x, W, U, b unchanged; exactly one update occurs.
- Write addr 5, then START with x=(2,-3) -> hidden=(-16,-49,-57,2) again. Assert reset mid-MUL -> hidden=0, state=LOAD.

Source files
------------

// File: rtl/rnn_accel.sv
// Elman RNN cell h = x*W + h*U + b behind a host register bus; START to idle takes 6 cycles.
// No backpressure: host writes are dropped unless idle, and reads are combinational.
module rnn_accel #(
    parameter int IN_LEN  = 2,
    parameter int HID_LEN = 4,
    parameter int DW      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int CW = $clog2(HID_LEN);
    localparam int IW = $clog2(IN_LEN);
    localparam logic [15:0] IN_LIM16  = 16'(IN_LEN);
    localparam logic [15:0] HID_LIM16 = 16'(HID_LEN);
    localparam logic [7:0]  IN_LIM8   = 8'(IN_LEN);
    localparam logic [7:0]  HID_LIM8  = 8'(HID_LEN);
    localparam logic [CW-1:0] LAST_COL = CW'(HID_LEN - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_MUL,
        S_UPDATE
    } state_t;

    state_t state;

    logic signed [DW-1:0] x      [IN_LEN];
    logic signed [DW-1:0] w      [IN_LEN][HID_LEN];
    logic signed [DW-1:0] u      [HID_LEN][HID_LEN];
    logic signed [DW-1:0] b      [HID_LEN];
    logic signed [DW-1:0] hidden [HID_LEN];
    logic signed [DW-1:0] wx     [HID_LEN];
    logic signed [DW-1:0] uh     [HID_LEN];

    logic [CW-1:0] col;
    logic          wx_rdy;
    logic          uh_rdy;

    logic signed [DW-1:0]   wx_col;
    logic signed [DW-1:0]   uh_col;
    logic signed [2*DW-1:0] wx_prod;
    logic signed [2*DW-1:0] uh_prod;

    // One output column per cycle; only the low DW bits of each product matter since sums wrap.
    always_comb begin
        wx_col  = '0;
        uh_col  = '0;
        wx_prod = '0;
        uh_prod = '0;
        for (int i = 0; i < IN_LEN; i++) begin
            wx_prod = x[i] * w[i][col];
            wx_col  = wx_col + wx_prod[DW-1:0];
        end
        for (int k = 0; k < HID_LEN; k++) begin
            uh_prod = hidden[k] * u[k][col];
            uh_col  = uh_col + uh_prod[DW-1:0];
        end
    end

    logic [15:0] idx16;
    logic [7:0]  row8;
    logic [7:0]  col8;
    logic [15:0] val16;

    assign idx16 = data_in[31:16];
    assign row8  = data_in[31:24];
    assign col8  = data_in[23:16];
    assign val16 = data_in[15:0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= S_LOAD;
            col    <= '0;
            wx_rdy <= 1'b0;
            uh_rdy <= 1'b0;
            for (int i = 0; i < IN_LEN; i++) begin
                x[i] <= '0;
                for (int j = 0; j < HID_LEN; j++) w[i][j] <= '0;
            end
            for (int j = 0; j < HID_LEN; j++) begin
                b[j]      <= '0;
                hidden[j] <= '0;
                wx[j]     <= '0;
                uh[j]     <= '0;
                for (int k = 0; k < HID_LEN; k++) u[j][k] <= '0;
            end
        end else begin
            wx_rdy <= 1'b0;
            uh_rdy <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (write) begin
                        case (addr[3:0])
                            4'd0: state <= S_START;
                            4'd1: if (idx16 < IN_LIM16) x[idx16[IW-1:0]] <= val16;
                            4'd2: if (row8 < IN_LIM8 && col8 < HID_LIM8)
                                      w[row8[IW-1:0]][col8[CW-1:0]] <= val16;
                            4'd3: if (row8 < HID_LIM8 && col8 < HID_LIM8)
                                      u[row8[CW-1:0]][col8[CW-1:0]] <= val16;
                            4'd4: if (idx16 < HID_LIM16) b[idx16[CW-1:0]] <= val16;
                            4'd5: for (int j = 0; j < HID_LEN; j++) hidden[j] <= '0;
                            default: ;
                        endcase
                    end
                end
                S_START: begin
                    for (int j = 0; j < HID_LEN; j++) begin
                        wx[j] <= '0;
                        uh[j] <= '0;
                    end
                    col   <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    wx[col] <= wx_col;
                    uh[col] <= uh_col;
                    col     <= col + 1'b1;
                    if (col == LAST_COL) begin
                        wx_rdy <= 1'b1;
                        uh_rdy <= 1'b1;
                        state  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    for (int j = 0; j < HID_LEN; j++) hidden[j] <= wx[j] + uh[j] + b[j];
                    state <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Reads ignore the strobe and decode only the low nibble.
    always_comb begin
        data_out = '0;
        if (!rst_n) begin
            case (addr[3:0])
                4'd0: data_out = {31'b0, state == S_LOAD};
                4'd8, 4'd9, 4'd10, 4'd11:
                    data_out = {{(32-DW){hidden[addr[CW-1:0]][DW-1]}}, hidden[addr[CW-1:0]]};
                default: data_out = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{read, addr[31:4], wx_rdy, uh_rdy};

endmodule

// File: tb/tb_rnn_accel.sv
// Randomised scoreboard bench for rnn_accel against a plain-arithmetic RNN reference model.
module tb_rnn_accel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    rnn_accel dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q [$];
    string       nm_q  [$];

    // Reference model state, each element held as a signed 16-bit value in an int.
    int mx [2];
    int mw [2][4];
    int mu [4][4];
    int mb [4];
    int mh [4];

    function automatic int wrap(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic logic [31:0] sx(input int v);
        return {{16{v[15]}}, v[15:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 0;
            for (int j = 0; j < 4; j++) mw[i][j] = 0;
        end
        for (int j = 0; j < 4; j++) begin
            mb[j] = 0;
            mh[j] = 0;
            for (int k = 0; k < 4; k++) mu[j][k] = 0;
        end
    endtask

    task automatic model_step();
        int nh [4];
        longint s;
        for (int j = 0; j < 4; j++) begin
            s = mb[j];
            for (int i = 0; i < 2; i++) s += longint'(mx[i]) * mw[i][j];
            for (int k = 0; k < 4; k++) s += longint'(mh[k]) * mu[k][j];
            nh[j] = wrap(s);
        end
        for (int j = 0; j < 4; j++) mh[j] = nh[j];
    endtask

    // Monitor: every cycle with the read strobe up is one scoreboard comparison.
    always @(negedge clk) begin
        if (read) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_read: got %08h, no expectation queued", data_out);
            end else begin
                logic [31:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                n_cmp++;
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL %s: addr=%08h got %08h expected %08h", nm, addr, data_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        write   = 1'b1;
        addr    = {28'h0, a};
        data_in = d;
        tick();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        read = 1'b1;
        addr = a;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        tick();
        read = 1'b0;
    endtask

    task automatic wr_x(input int idx, input int v);
        bus_write(4'd1, {idx[15:0], v[15:0]});
        if (idx >= 0 && idx < 2) mx[idx] = wrap(v);
    endtask

    task automatic wr_w(input int r, input int c, input int v);
        bus_write(4'd2, {r[7:0], c[7:0], v[15:0]});
        if (r >= 0 && r < 2 && c >= 0 && c < 4) mw[r][c] = wrap(v);
    endtask

    task automatic wr_u(input int r, input int c, input int v);
        bus_write(4'd3, {r[7:0], c[7:0], v[15:0]});
        if (r >= 0 && r < 4 && c >= 0 && c < 4) mu[r][c] = wrap(v);
    endtask

    task automatic wr_b(input int idx, input int v);
        bus_write(4'd4, {idx[15:0], v[15:0]});
        if (idx >= 0 && idx < 4) mb[idx] = wrap(v);
    endtask

    task automatic check_hidden(input string nm);
        for (int j = 0; j < 4; j++) do_read(32'd8 + 32'(j), sx(mh[j]), nm);
    endtask

    // START issued together with a read of the idle flag (write applies, read shows pre-edge state),
    // then the idle flag is tracked every cycle: busy for 6 cycles, idle on the 7th.
    task automatic start_check(input string nm);
        write   = 1'b1;
        read    = 1'b1;
        addr    = 32'd0;
        data_in = 32'd0;
        exp_q.push_back(32'd1);
        nm_q.push_back("start_rw_idle");
        tick();
        write = 1'b0;
        model_step();
        for (int i = 0; i < 7; i++) do_read(32'd0, (i == 6) ? 32'd1 : 32'd0, "done_timing");
        check_hidden(nm);
    endtask

    task automatic wait_done();
        bit ok = 0;
        read = 1'b0;
        addr = 32'd0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (data_out[0] === 1'b1) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_done: idle flag still %0b after 50 cycles, required 1", data_out[0]);
        end
        tick();
    endtask

    task automatic check_reset_state();
        do_read(32'd0, 32'd1, "reset_idle");
        check_hidden("reset_hidden");
        do_read(32'd5, 32'd0, "reset_unmapped");
    endtask

    initial begin
        int wrows [2][4] = '{'{2, -10, -10, 3}, '{6, 9, 12, 1}};
        int urows [4][4] = '{'{-2, -3, -5, -3}, '{-1, 10, -2, -6}, '{4, 11, 3, -12}, '{-11, -4, 3, -1}};
        int bvec  [4]    = '{-2, -2, -1, -1};

        rst_n   = 1'b1;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 32'd0;
        data_in = 32'd0;
        model_reset();
        tick();
        tick();
        do_read(32'd0, 32'd0, "data_out_in_reset");
        rst_n = 1'b0;
        check_reset_state();

        // Directed vectors.
        wr_x(0, 2);
        do_read(32'd0, 32'd1, "idle_after_write");
        wr_x(1, -3);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) wr_w(r, c, wrows[r][c]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wr_u(r, c, urows[r][c]);
        for (int j = 0; j < 4; j++) wr_b(j, bvec[j]);
        start_check("hidden_step1");
        wr_x(0, -8);
        wr_x(1, 3);
        start_check("hidden_step2");

        // Writes while busy must all be dropped, and only one update may happen.
        bus_write(4'd0, 32'd0);
        model_step();
        bus_write(4'd1, {16'd0, 16'h1234});
        bus_write(4'd2, {8'd1, 8'd2, 16'h0777});
        bus_write(4'd3, {8'd3, 8'd3, 16'h0555});
        bus_write(4'd4, {16'd2, 16'h0100});
        bus_write(4'd0, 32'd0);
        bus_write(4'd5, 32'd0);
        wait_done();
        check_hidden("busy_writes_ignored");
        repeat (5) tick();
        check_hidden("single_update");
        start_check("weights_unchanged");

        // Clearing the recurrence reproduces the first result.
        bus_write(4'd5, 32'd0);
        for (int j = 0; j < 4; j++) mh[j] = 0;
        check_hidden("hidden_cleared");
        wr_x(0, 2);
        wr_x(1, -3);
        start_check("hidden_after_clear");

        // Upper address bits are not decoded.
        do_read(32'hABCD_0008, sx(mh[0]), "addr_alias");
        do_read(32'd12, 32'd0, "unmapped_12");

        // Randomised operand updates (including out-of-range indices) and repeated steps.
        for (int it = 0; it < 25; it++) begin
            int n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                int v = int'($urandom_range(0, 65535));
                case ($urandom_range(0, 3))
                    0: wr_x($urandom_range(0, 2), v);
                    1: wr_w($urandom_range(0, 2), $urandom_range(0, 4), v);
                    2: wr_u($urandom_range(0, 4), $urandom_range(0, 4), v);
                    default: wr_b($urandom_range(0, 5), v);
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                bus_write(4'd5, 32'd0);
                for (int j = 0; j < 4; j++) mh[j] = 0;
            end
            if ($urandom_range(0, 5) == 0) bus_write(4'($urandom_range(6, 15)), $urandom());
            start_check("hidden_random");
            do_read({$urandom_range(0, 255), 4'd0} + 32'($urandom_range(12, 15)), 32'd0, "unmapped_rand");
        end

        // Reset in the middle of the multiply phase.
        bus_write(4'd0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        model_reset();
        check_reset_state();
        start_check("after_mid_reset");

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
